// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 ASCII keyboard front end.
// Holds the `state` output encodings, special scan codes and a few ASCII constants.
package kbd_pkg;

  // `state` encodings seen by the game core; 2'b11 is never driven.
  typedef enum logic [1:0] {
    KS_IDLE = 2'b00,
    KS_NEW  = 2'b01,
    KS_HELD = 2'b10
  } kbd_state_e;

  // Scan code set 2 prefixes and modifier keys.
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Non-printing keys that still produce an ASCII byte.
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational scan code (set 2) to ASCII map.
// Ports:
//   code_i   - make code to translate
//   upper_i  - uppercase letters (shift XOR caps); digits and other keys ignore it
//   ascii_o  - ASCII byte, 0 when unmapped
//   mapped_o - high when code_i has an ASCII translation
module ps2_scan2ascii
  import kbd_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       upper_i,
  output logic [7:0] ascii_o,
  output logic       mapped_o
);

  logic [7:0] base;
  logic       is_letter;

  always_comb begin
    base      = 8'h00;
    is_letter = 1'b1;
    mapped_o  = 1'b1;
    case (code_i)
      8'h1C: base = 8'h61; // a
      8'h32: base = 8'h62; // b
      8'h21: base = 8'h63; // c
      8'h23: base = 8'h64; // d
      8'h24: base = 8'h65; // e
      8'h2B: base = 8'h66; // f
      8'h34: base = 8'h67; // g
      8'h33: base = 8'h68; // h
      8'h43: base = 8'h69; // i
      8'h3B: base = 8'h6A; // j
      8'h42: base = 8'h6B; // k
      8'h4B: base = 8'h6C; // l
      8'h3A: base = 8'h6D; // m
      8'h31: base = 8'h6E; // n
      8'h44: base = 8'h6F; // o
      8'h4D: base = 8'h70; // p
      8'h15: base = 8'h71; // q
      8'h2D: base = 8'h72; // r
      8'h1B: base = 8'h73; // s
      8'h2C: base = 8'h74; // t
      8'h3C: base = 8'h75; // u
      8'h2A: base = 8'h76; // v
      8'h1D: base = 8'h77; // w
      8'h22: base = 8'h78; // x
      8'h35: base = 8'h79; // y
      8'h1A: base = 8'h7A; // z
      default: begin
        is_letter = 1'b0;
        case (code_i)
          8'h45:     base = 8'h30;
          8'h16:     base = 8'h31;
          8'h1E:     base = 8'h32;
          8'h26:     base = 8'h33;
          8'h25:     base = 8'h34;
          8'h2E:     base = 8'h35;
          8'h36:     base = 8'h36;
          8'h3D:     base = 8'h37;
          8'h3E:     base = 8'h38;
          8'h46:     base = 8'h39;
          SC_SPACE:  base = ASCII_SPACE;
          SC_ENTER:  base = ASCII_CR;
          SC_BKSP:   base = ASCII_BS;
          default:   mapped_o = 1'b0;
        endcase
      end
    endcase
    ascii_o = (is_letter && upper_i) ? (base - 8'h20) : base;
  end

endmodule

// File: rtl/ps2_ascii_kbd.sv
// PS/2 keyboard front end: frame receiver plus make/break decoder producing an ASCII byte
// and a 2-bit keystroke state for the game core.
// Ports:
//   clk, reset         - system clock, asynchronous active-high reset
//   ps2_clk, ps2_data  - raw asynchronous PS/2 lines
//   kbd_ascii          - ASCII of the most recent reported keystroke
//   state              - 00 idle, 01 new keystroke, 10 held (already reported)
//   scan_code          - last accepted scan code, prefixes included
//   frame_err          - one-cycle pulse on start/parity/stop error or timeout
//   caps               - Caps Lock toggle state
module ps2_ascii_kbd
  import kbd_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kbd_ascii,
  output logic [1:0] state,
  output logic [7:0] scan_code,
  output logic       frame_err,
  output logic       caps
);

  localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);
  localparam int unsigned PulseW = $clog2(PULSE_CYCLES);
  localparam logic [TmoW-1:0]   TmoMax    = TmoW'(TIMEOUT);
  // Loaded with N-1 and counted down to 0 inclusive, so KS_NEW lasts N cycles.
  localparam logic [PulseW-1:0] PulseLoad = PulseW'(PULSE_CYCLES - 1);

  // ---------------- Frame receiver ----------------
  logic [2:0]      clk_sync_q, data_sync_q;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      sr_q, sr_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            fall, bit_in, frame_done, frame_ok, tmo_abort;
  logic            code_vld_q, frame_err_q;
  logic [7:0]      scan_code_q;

  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_in = data_sync_q[2];
  // sr_q holds start (bit 0), d0..d7, parity (bit 9); bit_in is the stop bit on the 11th edge.
  assign frame_ok = ~sr_q[0] & bit_in & (^sr_q[9:1]);

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    tmo_d      = tmo_q;
    frame_done = 1'b0;
    tmo_abort  = 1'b0;
    if (fall) begin
      tmo_d = '0;
      if (bit_cnt_q == 4'd10) begin
        frame_done = 1'b1;
        bit_cnt_d  = 4'd0;
      end else begin
        sr_d      = {bit_in, sr_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else begin
      if (tmo_q != TmoMax) tmo_d = tmo_q + 1'b1;
      if (tmo_q == TmoMax && bit_cnt_q != 4'd0) begin
        tmo_abort = 1'b1;
        bit_cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Lines idle high; presetting avoids a phantom edge when reset releases.
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      tmo_q       <= '0;
      code_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      scan_code_q <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[1:0], ps2_data};
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      tmo_q       <= tmo_d;
      code_vld_q  <= frame_done & frame_ok;
      frame_err_q <= (frame_done & ~frame_ok) | tmo_abort;
      if (frame_done && frame_ok) scan_code_q <= sr_q[8:1];
    end
  end

  // ---------------- Decoder ----------------
  kbd_state_e      state_q, state_d;
  logic [PulseW-1:0] pulse_q, pulse_d;
  logic            brk_q, brk_d, ext_q, ext_d;
  logic            shl_q, shl_d, shr_q, shr_d;
  logic            caps_q, caps_d, caps_down_q, caps_down_d;
  logic [7:0]      held_q, held_d, ascii_q, ascii_d;
  logic [7:0]      map_ascii;
  logic            map_mapped;

  ps2_scan2ascii u_map (
    .code_i   (scan_code_q),
    .upper_i  ((shl_q | shr_q) ^ caps_q),
    .ascii_o  (map_ascii),
    .mapped_o (map_mapped)
  );

  always_comb begin
    state_d     = state_q;
    pulse_d     = pulse_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    shl_d       = shl_q;
    shr_d       = shr_q;
    caps_d      = caps_q;
    caps_down_d = caps_down_q;
    held_d      = held_q;
    ascii_d     = ascii_q;

    if (state_q == KS_NEW) begin
      if (pulse_q == '0) state_d = KS_HELD;
      else               pulse_d = pulse_q - 1'b1;
    end

    // A decoded code in the same cycle overrides the countdown above.
    if (code_vld_q) begin
      if (scan_code_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (scan_code_q == SC_BRK) begin
        brk_d = 1'b1;
      end else if (ext_q) begin
        // Extended keys (incl. their breaks) are not used by the game.
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        brk_d = 1'b0;
        if (scan_code_q == SC_LSHIFT) shl_d = 1'b0;
        if (scan_code_q == SC_RSHIFT) shr_d = 1'b0;
        if (scan_code_q == SC_CAPS)   caps_down_d = 1'b0;
        if (scan_code_q == held_q)    state_d = KS_IDLE;
      end else begin
        if (scan_code_q == SC_LSHIFT) shl_d = 1'b1;
        if (scan_code_q == SC_RSHIFT) shr_d = 1'b1;
        if (scan_code_q == SC_CAPS) begin
          // Typematic repeats of Caps Lock must not toggle again.
          if (!caps_down_q) caps_d = ~caps_q;
          caps_down_d = 1'b1;
        end
        if (!(scan_code_q == held_q && state_q != KS_IDLE) && map_mapped) begin
          ascii_d = map_ascii;
          held_d  = scan_code_q;
          state_d = KS_NEW;
          pulse_d = PulseLoad;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= KS_IDLE;
      pulse_q     <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      shl_q       <= 1'b0;
      shr_q       <= 1'b0;
      caps_q      <= 1'b0;
      caps_down_q <= 1'b0;
      held_q      <= '0;
      ascii_q     <= '0;
    end else begin
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      shl_q       <= shl_d;
      shr_q       <= shr_d;
      caps_q      <= caps_d;
      caps_down_q <= caps_down_d;
      held_q      <= held_d;
      ascii_q     <= ascii_d;
    end
  end

  assign kbd_ascii = ascii_q;
  assign state     = state_q;
  assign scan_code = scan_code_q;
  assign frame_err = frame_err_q;
  assign caps      = caps_q;

endmodule

// File: tb/tb_ps2_ascii_kbd.sv
// Self-checking bench for ps2_ascii_kbd: directed test-plan sequences plus random key
// streams, compared against a keystroke-level reference model.
module tb_ps2_ascii_kbd;

  localparam int Tmo = 600;
  localparam int H   = 8;   // PS/2 half period in clk cycles

  logic clk = 1'b0;
  logic reset, ps2_clk, ps2_data;
  logic [7:0] kbd_ascii, scan_code;
  logic [1:0] state;
  logic       frame_err, caps;
  logic [7:0] l_ascii, l_scan;
  logic [1:0] l_state;
  logic       l_ferr, l_caps;

  always #10 clk = ~clk;

  ps2_ascii_kbd #(.PULSE_CYCLES(4), .TIMEOUT(Tmo)) u_dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kbd_ascii(kbd_ascii), .state(state), .scan_code(scan_code),
    .frame_err(frame_err), .caps(caps)
  );

  // Long pulse so back-to-back keystrokes land inside the 01 window.
  ps2_ascii_kbd #(.PULSE_CYCLES(2000), .TIMEOUT(Tmo)) u_long (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kbd_ascii(l_ascii), .state(l_state), .scan_code(l_scan),
    .frame_err(l_ferr), .caps(l_caps)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- Reference model ----------------
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46};

  bit m_brk, m_ext, m_shl, m_shr, m_caps, m_caps_down;
  logic [7:0] m_held, m_ascii, m_scan;
  int m_st;  // settled key state: 0 idle or 2 held

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_caps_down = 0;
    m_held = 0; m_ascii = 0; m_scan = 0; m_st = 0;
  endtask

  task automatic lookup(input logic [7:0] c, input bit up, output bit ok, output logic [7:0] a);
    ok = 0; a = 0;
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == c) begin ok = 1; a = 8'(8'h61 + i - (up ? 8'h20 : 8'h00)); end
    for (int i = 0; i < 10; i++)
      if (digit_sc[i] == c) begin ok = 1; a = 8'(8'h30 + i); end
    if (c == 8'h29) begin ok = 1; a = 8'h20; end
    if (c == 8'h5A) begin ok = 1; a = 8'h0D; end
    if (c == 8'h66) begin ok = 1; a = 8'h08; end
  endtask

  task automatic model_code(input logic [7:0] c, output bit is_new);
    bit ok;
    logic [7:0] a;
    is_new = 0;
    if (c == 8'hE0) m_ext = 1;
    else if (c == 8'hF0) m_brk = 1;
    else if (m_ext) begin m_ext = 0; m_brk = 0; end
    else if (m_brk) begin
      m_brk = 0;
      if (c == 8'h12) m_shl = 0;
      if (c == 8'h59) m_shr = 0;
      if (c == 8'h58) m_caps_down = 0;
      if (c == m_held) m_st = 0;
    end else begin
      if (c == 8'h12) m_shl = 1;
      if (c == 8'h59) m_shr = 1;
      if (c == 8'h58) begin
        if (!m_caps_down) m_caps = !m_caps;
        m_caps_down = 1;
      end
      lookup(c, (m_shl | m_shr) ^ m_caps, ok, a);
      if (!(c == m_held && m_st != 0) && ok) begin
        m_ascii = a; m_held = c; m_st = 2; is_new = 1;
      end
    end
  endtask

  // ---------------- Stimulus ----------------
  // Sends nbits of a frame; a full frame returns with ps2_clk just driven low.
  task automatic send_frame(input logic [7:0] code, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (i != 10) begin
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic do_frame(input logic [7:0] c, input bit bad_par);
    bit nw;
    nw = 0;
    send_frame(c, bad_par, 11);
    // Edge seen after 2 sync stages, frame result one cycle later, state one more.
    repeat (3) @(posedge clk); #1;
    if (bad_par) begin
      check_eq("perr_pulse", frame_err, 1);
      check_eq("perr_scan", scan_code, m_scan);
    end else begin
      model_code(c, nw);
      m_scan = c;
      check_eq("scan_code", scan_code, c);
      check_eq("no_ferr", frame_err, 0);
    end
    @(posedge clk); #1;
    check_eq("state", state, nw ? 1 : m_st);
    check_eq("ascii", kbd_ascii, m_ascii);
    check_eq("caps", caps, m_caps);
    if (nw) begin
      repeat (3) @(posedge clk); #1;
      check_eq("pulse_last", state, 1);
      @(posedge clk); #1;
      check_eq("pulse_end", state, 2);
    end
    @(negedge clk);
    ps2_clk = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ascii"}, kbd_ascii, 0);
    check_eq({tag, "_state"}, state, 0);
    check_eq({tag, "_scan"}, scan_code, 0);
    check_eq({tag, "_ferr"}, frame_err, 0);
    check_eq({tag, "_caps"}, caps, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] pool [20] = '{8'h1C, 8'h32, 8'h21, 8'h15, 8'h1A, 8'h45, 8'h16, 8'h29, 8'h5A,
                            8'h66, 8'h12, 8'h59, 8'h58, 8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'h75,
                            8'h05, 8'h2B};

  initial begin
    int seen;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    model_reset();
    apply_reset();

    // Single keystroke, typematic repeats, then break.
    do_frame(8'h1C, 0);
    repeat (3) do_frame(8'h1C, 0);
    do_frame(8'hF0, 0);
    do_frame(8'h1C, 0);
    check_eq("brk_ascii", kbd_ascii, 8'h61);

    // Shift and Caps Lock.
    do_frame(8'h12, 0); do_frame(8'h32, 0);
    check_eq("shift_b", kbd_ascii, 8'h42);
    do_frame(8'hF0, 0); do_frame(8'h12, 0);
    do_frame(8'h58, 0); do_frame(8'h15, 0);
    check_eq("caps_q", kbd_ascii, 8'h51);
    check_eq("caps_on", caps, 1);
    apply_reset();
    do_frame(8'h58, 0); do_frame(8'h12, 0); do_frame(8'h15, 0);
    check_eq("caps_shift_q", kbd_ascii, 8'h71);

    // Bad parity leaves everything alone.
    do_frame(8'h1C, 1);

    // Partial frame then idle: exactly one timeout error.
    send_frame(8'h1C, 0, 6);
    seen = 0;
    for (int i = 0; i < Tmo + 50; i++) begin
      @(posedge clk); #1;
      if (frame_err) seen++;
    end
    check_eq("tmo_pulses", seen, 1);
    do_frame(8'h32, 0);
    check_eq("after_tmo", kbd_ascii, 8'h62);

    // Extended keys are discarded.
    do_frame(8'hE0, 0); do_frame(8'h75, 0);
    do_frame(8'hE0, 0); do_frame(8'hF0, 0); do_frame(8'h75, 0);
    do_frame(8'h1C, 0);

    // Reload during 01 (long-pulse instance), break of non-held vs held key.
    apply_reset();
    do_frame(8'h1C, 0);
    check_eq("long_new", l_state, 1);
    do_frame(8'h32, 0);
    check_eq("long_reload_st", l_state, 1);
    check_eq("long_reload_a", l_ascii, 8'h62);
    do_frame(8'hF0, 0); do_frame(8'h1C, 0);
    check_eq("long_brk_other", l_state, 1);
    check_eq("main_brk_other", state, 2);
    do_frame(8'hF0, 0); do_frame(8'h32, 0);
    check_eq("long_brk_held", l_state, 0);
    check_eq("long_brk_ascii", l_ascii, 8'h62);

    // Random key streams.
    for (int n = 0; n < 90; n++)
      do_frame(pool[$urandom_range(0, 19)], ($urandom_range(0, 15) == 0));

    // Reset mid-frame.
    send_frame(8'h1C, 0, 6);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    do_frame(8'h29, 0);
    check_eq("space", kbd_ascii, 8'h20);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
